// File: rtl/soc_bus_periph_if.sv
// soc_bus_periph_if
//   System data bus between the core's MEM-stage master port and the
//   memory-mapped slave subsystem.
//   sys_bus_request : access valid this cycle
//   sys_bus_we      : write strobe, qualified by request
//   sys_bus_adr     : byte address
//   sys_bus_op      : access type, RV32I funct3 encoding
//   sys_bus_wdata   : write data, right-aligned
//   sys_bus_rdata   : read data, combinational from the slave
interface soc_bus_periph_if;
    logic        sys_bus_request;
    logic        sys_bus_we;
    logic [31:0] sys_bus_adr;
    logic [2:0]  sys_bus_op;
    logic [31:0] sys_bus_wdata;
    logic [31:0] sys_bus_rdata;

    modport master (
        output sys_bus_request, sys_bus_we, sys_bus_adr, sys_bus_op, sys_bus_wdata,
        input  sys_bus_rdata
    );

    modport slave (
        input  sys_bus_request, sys_bus_we, sys_bus_adr, sys_bus_op, sys_bus_wdata,
        output sys_bus_rdata
    );
endinterface

// File: rtl/soc_bus_periph.sv
// soc_bus_periph
//   Decodes the system data bus onto a byte-addressable data RAM and an
//   optional programmable interval timer.
//   Parameters: DRAM_WORDS (RAM depth in 32-bit words), TIMER_BASE (timer
//   register block base address).
//   Ports:
//     clk      : system clock, rising edge
//     rst      : synchronous active-high reset
//     bus      : soc_bus_periph_if.slave, request/we/adr/op/wdata in, rdata out
//     int_sig  : timer interrupt request, level
//   Build macro SOC_TIMER_EN: when defined the timer is present
//   (+0 ctrl, +4 count, +8 value); when undefined the timer range decodes
//   as unmapped and int_sig is tied low.
module soc_bus_periph #(
    parameter int          DRAM_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    soc_bus_periph_if.slave        bus,
    output logic                   int_sig
);

    localparam int          AW        = (DRAM_WORDS > 1) ? $clog2(DRAM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DRAM_WORDS);

    // RAM storage has no reset and no _d shadow; byte lanes are written in place.
    logic [31:0] mem_q [DRAM_WORDS];

    logic          wr_en;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic          sel_ctrl, sel_count, sel_value, tmr_hit;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [31:0]   ram_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ram_load;
    logic [31:0]   tmr_rdata;

    always_comb begin
        wr_en     = bus.sys_bus_request & bus.sys_bus_we;
        ram_hit   = bus.sys_bus_adr < RAM_BYTES;
        ram_idx   = bus.sys_bus_adr[AW+1:2];
        // Timer block is word-aligned, so matching adr[31:2] covers [BASE, BASE+12).
        sel_ctrl  = bus.sys_bus_adr[31:2] == TIMER_BASE[31:2];
        sel_count = bus.sys_bus_adr[31:2] == (TIMER_BASE[31:2] + 30'd1);
        sel_value = bus.sys_bus_adr[31:2] == (TIMER_BASE[31:2] + 30'd2);
        tmr_hit   = sel_ctrl | sel_count | sel_value;
    end

    // Store lane enables; data is replicated so every enabled lane sees it.
    always_comb begin
        st_be   = 4'hF;
        st_data = bus.sys_bus_wdata;
        case (bus.sys_bus_op)
            3'b000: begin
                st_be   = 4'b0001 << bus.sys_bus_adr[1:0];
                st_data = {4{bus.sys_bus_wdata[7:0]}};
            end
            3'b001: begin
                st_be   = bus.sys_bus_adr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.sys_bus_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem_q[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        ram_word = mem_q[ram_idx];
        ld_byte  = ram_word[{bus.sys_bus_adr[1:0], 3'b000} +: 8];
        ld_half  = bus.sys_bus_adr[1] ? ram_word[31:16] : ram_word[15:0];
        case (bus.sys_bus_op)
            3'b000:  ram_load = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ram_load = {24'h0, ld_byte};
            3'b001:  ram_load = {{16{ld_half[15]}}, ld_half};
            3'b101:  ram_load = {16'h0, ld_half};
            default: ram_load = ram_word;
        endcase
    end

`ifdef SOC_TIMER_EN
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [31:0] count_q, count_d;
    logic [31:0] value_q, value_d;
    logic        wr_ctrl, wr_count, wr_value;
    logic        cnt_go, match;

    always_comb begin
        wr_ctrl  = wr_en & sel_ctrl;
        wr_count = wr_en & sel_count;
        wr_value = wr_en & sel_value;
        // A ctrl write that clears enable also suppresses this edge's count step.
        cnt_go   = en_q & ~(wr_ctrl & ~bus.sys_bus_wdata[0]);
        match    = cnt_go & (count_q == value_q);

        en_d     = en_q;
        ie_d     = ie_q;
        value_d  = value_q;
        count_d  = count_q;
        if (cnt_go)   count_d = match ? 32'h0 : count_q + 32'd1;
        if (wr_count) count_d = bus.sys_bus_wdata;
        if (wr_value) value_d = bus.sys_bus_wdata;
        if (wr_ctrl) begin
            en_d = bus.sys_bus_wdata[0];
            ie_d = bus.sys_bus_wdata[1];
        end
        // A new match outranks a simultaneous write-1-to-clear.
        pend_d   = match | (pend_q & ~(wr_ctrl & bus.sys_bus_wdata[2]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            count_q <= 32'h0;
            value_q <= 32'h0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        tmr_rdata = 32'h0;
        if (sel_ctrl)       tmr_rdata = {29'h0, pend_q, ie_q, en_q};
        else if (sel_count) tmr_rdata = count_q;
        else if (sel_value) tmr_rdata = value_q;
    end

    assign int_sig = pend_q & ie_q;
`else
    assign tmr_rdata = 32'h0;
    assign int_sig   = 1'b0;
`endif

    always_comb begin
        if (ram_hit)      bus.sys_bus_rdata = ram_load;
        else if (tmr_hit) bus.sys_bus_rdata = tmr_rdata;
        else              bus.sys_bus_rdata = 32'h0;
    end

endmodule

// File: tb/tb_soc_bus_periph.sv
module tb_soc_bus_periph;
    localparam logic [31:0] TB_BASE = 32'h4000_0000;
    localparam logic [31:0] A_CTRL  = TB_BASE;
    localparam logic [31:0] A_COUNT = TB_BASE + 32'd4;
    localparam logic [31:0] A_VALUE = TB_BASE + 32'd8;

    logic clk = 1'b0;
    logic rst;
    logic int_sig;

    soc_bus_periph_if bus();

    soc_bus_periph #(.DRAM_WORDS(1024), .TIMER_BASE(TB_BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus), .int_sig(int_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        string       name;
        bit          we;
        logic [31:0] adr;
        logic [2:0]  op;
        logic [31:0] data;   // write data for stores, expected rdata for loads
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string name, bit we, logic [31:0] adr, logic [2:0] op, logic [31:0] data);
        vec_t v;
        v.name = name; v.we = we; v.adr = adr; v.op = op; v.data = data;
        return v;
    endfunction

    task automatic sb_push(string name, logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic bus_write(logic [31:0] adr, logic [2:0] op, logic [31:0] data);
        @(negedge clk);
        bus.sys_bus_request = 1'b1;
        bus.sys_bus_we      = 1'b1;
        bus.sys_bus_adr     = adr;
        bus.sys_bus_op      = op;
        bus.sys_bus_wdata   = data;
        @(negedge clk);
        bus.sys_bus_request = 1'b0;
        bus.sys_bus_we      = 1'b0;
    endtask

    task automatic bus_read(logic [31:0] adr, logic [2:0] op, output logic [31:0] got);
        @(negedge clk);
        bus.sys_bus_request = 1'b1;
        bus.sys_bus_we      = 1'b0;
        bus.sys_bus_adr     = adr;
        bus.sys_bus_op      = op;
        #1;
        got = bus.sys_bus_rdata;
        bus.sys_bus_request = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        exp_t e;
        logic [31:0] regs [3];
        regs[0] = A_CTRL; regs[1] = A_COUNT; regs[2] = A_VALUE;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_push("rst_int_sig", 32'h0);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("rst_reg%0d", i), 32'h0);
            bus_read(regs[i], 3'b010, got);
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_ram_access();
        vec_t tbl[$];
        logic [31:0] got;
        exp_t e;
        tbl.push_back(mk("sw10",   1, 32'h10,  3'b010, 32'h1234_5678));
        tbl.push_back(mk("lb11",   0, 32'h11,  3'b000, 32'h0000_0056));
        tbl.push_back(mk("lh12",   0, 32'h12,  3'b001, 32'h0000_1234));
        tbl.push_back(mk("lw10",   0, 32'h10,  3'b010, 32'h1234_5678));
        tbl.push_back(mk("lbu13",  0, 32'h13,  3'b100, 32'h0000_0012));
        tbl.push_back(mk("lh13",   0, 32'h13,  3'b001, 32'h0000_1234));
        tbl.push_back(mk("lhu10",  0, 32'h10,  3'b101, 32'h0000_5678));
        tbl.push_back(mk("sw20",   1, 32'h20,  3'b010, 32'h0000_0000));
        tbl.push_back(mk("sb20",   1, 32'h20,  3'b000, 32'h0000_0080));
        tbl.push_back(mk("lb20",   0, 32'h20,  3'b000, 32'hFFFF_FF80));
        tbl.push_back(mk("lbu20",  0, 32'h20,  3'b100, 32'h0000_0080));
        tbl.push_back(mk("lw20",   0, 32'h20,  3'b010, 32'h0000_0080));
        tbl.push_back(mk("sh22",   1, 32'h22,  3'b001, 32'hABCD_8001));
        tbl.push_back(mk("lh22",   0, 32'h22,  3'b001, 32'hFFFF_8001));
        tbl.push_back(mk("lhu23",  0, 32'h23,  3'b101, 32'h0000_8001));
        tbl.push_back(mk("lw20b",  0, 32'h20,  3'b010, 32'h8001_0080));
        tbl.push_back(mk("sb23",   1, 32'h23,  3'b000, 32'h1234_567F));
        tbl.push_back(mk("lw21",   0, 32'h21,  3'b010, 32'h7F01_0080));
        tbl.push_back(mk("lb21",   0, 32'h21,  3'b000, 32'h0000_0000));
        tbl.push_back(mk("sw30op3",1, 32'h30,  3'b011, 32'hA5A5_5A5A));
        tbl.push_back(mk("lw30op7",0, 32'h30,  3'b111, 32'hA5A5_5A5A));
        tbl.push_back(mk("lw30op6",0, 32'h31,  3'b110, 32'hA5A5_5A5A));
        tbl.push_back(mk("swffc",  1, 32'hFFC, 3'b010, 32'hDEAD_BEEF));
        tbl.push_back(mk("lwffc",  0, 32'hFFC, 3'b010, 32'hDEAD_BEEF));
        tbl.push_back(mk("lbffe",  0, 32'hFFE, 3'b000, 32'hFFFF_FFAD));
        foreach (tbl[i]) begin
            if (tbl[i].we) begin
                bus_write(tbl[i].adr, tbl[i].op, tbl[i].data);
            end else begin
                sb_push(tbl[i].name, tbl[i].data);
                bus_read(tbl[i].adr, tbl[i].op, got);
                e = sb_q.pop_front();
                n_vec++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_unmapped();
        vec_t tbl[$];
        logic [31:0] got;
        exp_t e;
        bus_write(32'h0000_0000, 3'b010, 32'hCAFE_F00D);
        bus_write(32'h0000_1000, 3'b010, 32'h1111_1111);
        bus_write(32'h8000_0000, 3'b010, 32'h2222_2222);
        bus_write(32'h8000_0010, 3'b010, 32'h3333_3333);
        // request low with we high must not store
        @(negedge clk);
        bus.sys_bus_request = 1'b0;
        bus.sys_bus_we      = 1'b1;
        bus.sys_bus_adr     = 32'h20;
        bus.sys_bus_op      = 3'b010;
        bus.sys_bus_wdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.sys_bus_we      = 1'b0;
        tbl.push_back(mk("rd1000",   0, 32'h0000_1000, 3'b010, 32'h0));
        tbl.push_back(mk("rd8000",   0, 32'h8000_0000, 3'b010, 32'h0));
        tbl.push_back(mk("rdtmrend", 0, TB_BASE + 32'd12, 3'b010, 32'h0));
        tbl.push_back(mk("ram0kept", 0, 32'h0000_0000, 3'b010, 32'hCAFE_F00D));
        tbl.push_back(mk("ram10kept",0, 32'h0000_0010, 3'b010, 32'h1234_5678));
        tbl.push_back(mk("noreqwr",  0, 32'h0000_0020, 3'b010, 32'h7F01_0080));
        foreach (tbl[i]) begin
            sb_push(tbl[i].name, tbl[i].data);
            bus_read(tbl[i].adr, tbl[i].op, got);
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
        // rdata follows the address even with request low
        @(negedge clk);
        bus.sys_bus_request = 1'b0;
        bus.sys_bus_adr     = 32'h10;
        bus.sys_bus_op      = 3'b010;
        sb_push("rd_noreq", 32'h1234_5678);
        #1;
        got = bus.sys_bus_rdata;
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
    endtask

`ifdef SOC_TIMER_EN
    task automatic test_timer_count();
        logic [31:0] got;
        exp_t e;
        bus_write(A_VALUE, 3'b010, 32'd5);
        bus_write(A_CTRL,  3'b010, 32'h3);
        bus.sys_bus_adr = A_COUNT;
        bus.sys_bus_op  = 3'b010;
        // after the k-th edge past enable: count = k mod 6, int_sig from the 6th edge on
        for (int k = 1; k <= 12; k++) begin
            sb_push($sformatf("count_e%0d", k), 32'(k % 6));
            sb_push($sformatf("int_e%0d", k), (k >= 6) ? 32'h1 : 32'h0);
            @(negedge clk);
            #1;
            got = bus.sys_bus_rdata;
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
            e = sb_q.pop_front();
            n_vec++;
            if ({31'h0, int_sig} !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
            end
        end
    endtask

    task automatic test_pending_clear();
        logic [31:0] got;
        exp_t e;
        // count 1 on the write edge: no match, so the clear takes
        bus_write(A_CTRL, 3'b010, 32'h7);
        sb_push("clr_int", 32'h0);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        sb_push("clr_ctrl", 32'h3);
        bus_read(A_CTRL, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
        // count 5 at the next write edge: match and clear collide
        @(negedge clk);
        bus_write(A_CTRL, 3'b010, 32'h7);
        sb_push("setwins_int", 32'h1);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        sb_push("setwins_ctrl", 32'h7);
        bus_read(A_CTRL, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
        sb_push("setwins_count", 32'd2);
        bus_read(A_COUNT, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
    endtask

    task automatic test_count_write_and_disable();
        logic [31:0] got;
        exp_t e;
        logic [31:0] exps [2];
        bus_write(A_COUNT, 3'b010, 32'h100);
        exps[0] = 32'h100; exps[1] = 32'h101;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("cntwr_%0d", i), exps[i]);
            if (i == 1) @(negedge clk);
            #1;
            got = bus.sys_bus_rdata;
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
        bus_write(A_COUNT, 3'b010, 32'h200);
        bus_write(A_CTRL,  3'b010, 32'h0);
        repeat (3) @(negedge clk);
        sb_push("dis_count", 32'h201);
        bus_read(A_COUNT, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
        sb_push("dis_ctrl", 32'h4);
        bus_read(A_CTRL, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
        sb_push("dis_int", 32'h0);
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
    endtask

    task automatic test_timer_zero();
        logic [31:0] got;
        exp_t e;
        bus_write(A_CTRL, 3'b010, 32'h3);
        repeat (3) @(negedge clk);
        sb_push("zero_int", 32'h1);
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        sb_push("zero_count", 32'h0);
        bus_read(A_COUNT, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
    endtask
`else
    task automatic test_timer_absent();
        logic [31:0] got;
        exp_t e;
        logic [31:0] regs [3];
        regs[0] = A_CTRL; regs[1] = A_COUNT; regs[2] = A_VALUE;
        bus_write(A_VALUE, 3'b010, 32'd5);
        bus_write(A_CTRL,  3'b010, 32'h3);
        repeat (10) @(negedge clk);
        sb_push("absent_int", 32'h0);
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("absent_reg%0d", i), 32'h0);
            bus_read(regs[i], 3'b010, got);
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    endtask
`endif

    task automatic test_reset_midrun();
        logic [31:0] got;
        exp_t e;
        vec_t tbl[$];
`ifdef SOC_TIMER_EN
        bus_write(A_VALUE, 3'b010, 32'h10);
        bus_write(A_COUNT, 3'b010, 32'h0);
        bus_write(A_CTRL,  3'b010, 32'h3);
        bus.sys_bus_adr = A_COUNT;
        bus.sys_bus_op  = 3'b010;
        repeat (3) @(negedge clk);
        sb_push("pre_rst_count", 32'd3);
        #1;
        got = bus.sys_bus_rdata;
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
        sb_push("pre_rst_ctrl", 32'h7);
        bus_read(A_CTRL, 3'b010, got);
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_push("midrst_int", 32'h0);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if ({31'h0, int_sig} !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, {31'h0, int_sig}, e.exp);
        end
        tbl.push_back(mk("midrst_ctrl",  0, A_CTRL,  3'b010, 32'h0));
        tbl.push_back(mk("midrst_count", 0, A_COUNT, 3'b010, 32'h0));
        tbl.push_back(mk("midrst_value", 0, A_VALUE, 3'b010, 32'h0));
        tbl.push_back(mk("midrst_ram10", 0, 32'h10,  3'b010, 32'h1234_5678));
        tbl.push_back(mk("midrst_ramffc",0, 32'hFFC, 3'b010, 32'hDEAD_BEEF));
        foreach (tbl[i]) begin
            sb_push(tbl[i].name, tbl[i].data);
            bus_read(tbl[i].adr, tbl[i].op, got);
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.sys_bus_request = 1'b0;
        bus.sys_bus_we      = 1'b0;
        bus.sys_bus_adr     = 32'h0;
        bus.sys_bus_op      = 3'b010;
        bus.sys_bus_wdata   = 32'h0;
        test_reset();
        test_ram_access();
        test_unmapped();
`ifdef SOC_TIMER_EN
        test_timer_count();
        test_pending_clear();
        test_count_write_and_disable();
`else
        test_timer_absent();
`endif
        test_reset_midrun();
`ifdef SOC_TIMER_EN
        test_timer_zero();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
